// File: rtl/axi_lite_cmd_master_pkg.sv
`default_nettype none
// ============================================================================
// AXI_Lite_Package : AXI4-Lite field types, response codes, master FSM states
// Rev 1.0
// ============================================================================
package AXI_Lite_Package;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;
    typedef logic [3:0]        cach_t;
    typedef logic [2:0]        prot_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } mst_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_intf.sv
`default_nettype none
// ============================================================================
// AXI_Lite_Intf : AXI4-Lite AW/W/B/AR/R channel bundle with Master/Slave views
// Rev 1.0
// ============================================================================
interface AXI_Lite_Intf;
    import AXI_Lite_Package::*;

    addr_t AWADDR;
    cach_t AWCACHE;
    prot_t AWPROT;
    logic  AWVALID;
    logic  AWREADY;
    data_t WDATA;
    strb_t WSTRB;
    logic  WVALID;
    logic  WREADY;
    resp_t BRESP;
    logic  BVALID;
    logic  BREADY;
    addr_t ARADDR;
    cach_t ARCACHE;
    prot_t ARPROT;
    logic  ARVALID;
    logic  ARREADY;
    data_t RDATA;
    resp_t RRESP;
    logic  RVALID;
    logic  RREADY;

    modport Master (
        output AWADDR, AWCACHE, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARCACHE, ARPROT, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport Slave (
        input  AWADDR, AWCACHE, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARCACHE, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// axi_lite_cmd_master : command/response port to single-outstanding AXI4-Lite
// Rev 1.0
// ============================================================================
module axi_lite_cmd_master
    import AXI_Lite_Package::*;
#(
    parameter cach_t AWCACHE_VAL = 4'b0011,
    parameter cach_t ARCACHE_VAL = 4'b0011,
    parameter prot_t PROT_VAL    = 3'b000
) (
    input  logic  ACLK,
    input  logic  ARESETN,
    input  logic  cmd_valid,
    output logic  cmd_ready,
    input  logic  cmd_write,
    input  addr_t cmd_addr,
    input  data_t cmd_wdata,
    input  strb_t cmd_wstrb,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output logic  rsp_write,
    output data_t rsp_rdata,
    output resp_t rsp_resp,
    AXI_Lite_Intf.Master axi
);

    mst_state_e r_state, w_state;
    logic  r_cmd_ready, w_cmd_ready;
    logic  r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_arvalid, w_arvalid;
    logic  r_bready, w_bready, r_rready, w_rready;
    logic  r_aw_done, w_aw_done, r_w_done, w_w_done;
    addr_t r_awaddr, w_awaddr, r_araddr, w_araddr;
    data_t r_wdata, w_wdata;
    strb_t r_wstrb, w_wstrb;
    logic  r_rsp_valid, w_rsp_valid, r_rsp_write, w_rsp_write;
    data_t r_rsp_rdata, w_rsp_rdata;
    resp_t r_rsp_resp, w_rsp_resp;
    logic  w_aw_hs, w_w_hs, w_ar_hs;

    assign w_aw_hs = r_awvalid & axi.AWREADY;
    assign w_w_hs  = r_wvalid  & axi.WREADY;
    assign w_ar_hs = r_arvalid & axi.ARREADY;

    always_comb begin
        w_state     = r_state;
        w_cmd_ready = r_cmd_ready;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_arvalid   = r_arvalid;
        w_bready    = r_bready;
        w_rready    = r_rready;
        w_aw_done   = r_aw_done;
        w_w_done    = r_w_done;
        w_awaddr    = r_awaddr;
        w_araddr    = r_araddr;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        w_rsp_valid = r_rsp_valid;
        w_rsp_write = r_rsp_write;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_resp  = r_rsp_resp;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    if (cmd_write) begin
                        w_awaddr  = cmd_addr;
                        w_wdata   = cmd_wdata;
                        w_wstrb   = cmd_wstrb;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_done = 1'b0;
                        w_w_done  = 1'b0;
                        w_state   = ST_WR_REQ;
                    end else begin
                        w_araddr  = cmd_addr;
                        w_arvalid = 1'b1;
                        w_state   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; each VALID drops only after its own handshake
                if (w_aw_hs) begin
                    w_awvalid = 1'b0;
                    w_aw_done = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid = 1'b0;
                    w_w_done = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_bready = 1'b1;
                    w_state  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (axi.BVALID && r_bready) begin
                    w_rsp_resp  = axi.BRESP;
                    w_rsp_rdata = '0;
                    w_rsp_write = 1'b1;
                    w_rsp_valid = 1'b1;
                    w_bready    = 1'b0;
                    w_state     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (w_ar_hs) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (axi.RVALID && r_rready) begin
                    w_rsp_resp  = axi.RRESP;
                    w_rsp_rdata = axi.RDATA;
                    w_rsp_write = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rready    = 1'b0;
                    w_state     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state     <= w_state;
            r_cmd_ready <= w_cmd_ready;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_arvalid   <= w_arvalid;
            r_bready    <= w_bready;
            r_rready    <= w_rready;
            r_aw_done   <= w_aw_done;
            r_w_done    <= w_w_done;
            r_awaddr    <= w_awaddr;
            r_araddr    <= w_araddr;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_write <= w_rsp_write;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_resp  <= w_rsp_resp;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign axi.AWADDR  = r_awaddr;
    assign axi.AWCACHE = AWCACHE_VAL;
    assign axi.AWPROT  = PROT_VAL;
    assign axi.AWVALID = r_awvalid;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WVALID  = r_wvalid;
    assign axi.BREADY  = r_bready;
    assign axi.ARADDR  = r_araddr;
    assign axi.ARCACHE = ARCACHE_VAL;
    assign axi.ARPROT  = PROT_VAL;
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_cmd_master : delay-programmable AXI-Lite slave + timeline model
// Rev 1.0
// ============================================================================
module tb_axi_lite_cmd_master;
    import AXI_Lite_Package::*;

    localparam int MAXW = 200;

    logic  ACLK = 1'b0;
    logic  ARESETN = 1'b0;
    logic  cmd_valid = 1'b0;
    logic  cmd_ready;
    logic  cmd_write = 1'b0;
    addr_t cmd_addr = '0;
    data_t cmd_wdata = '0;
    strb_t cmd_wstrb = '0;
    logic  rsp_valid;
    logic  rsp_ready = 1'b0;
    logic  rsp_write;
    data_t rsp_rdata;
    resp_t rsp_resp;

    int checks = 0;
    int failures = 0;

    AXI_Lite_Intf axi_if();

    axi_lite_cmd_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .axi(axi_if)
    );

    always #5 ACLK = ~ACLK;

    // Slave: each READY/VALID it drives rises a programmable number of cycles late
    int    aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    resp_t cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    data_t cfg_rdata = '0;
    bit    aw_got, w_got, ar_got, wr_armed, b_pend, b_fire, r_pend, r_fire;
    bit    aw_wait, w_wait, ar_wait;
    int    aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    addr_t aw_prev, ar_prev;
    logic [DATA_W+STRB_W-1:0] w_prev;
    addr_t aw_q[$];
    data_t wd_q[$];
    strb_t ws_q[$];
    addr_t ar_q[$];
    int    b_hs = 0, r_hs = 0, proto_err = 0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            axi_if.AWREADY = 1'b0; axi_if.WREADY = 1'b0; axi_if.ARREADY = 1'b0;
            axi_if.BVALID = 1'b0;  axi_if.RVALID = 1'b0;
            axi_if.BRESP = '0; axi_if.RRESP = '0; axi_if.RDATA = '0;
            aw_got = 0; w_got = 0; ar_got = 0; wr_armed = 0;
            b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            if (axi_if.BREADY && !b_pend) proto_err++;
            if (axi_if.RREADY && !r_pend) proto_err++;
            if (b_fire) begin axi_if.BVALID = 1'b0; b_fire = 0; end
            if (b_pend && !axi_if.BVALID) begin
                if (b_cnt == b_dly) begin axi_if.BVALID = 1'b1; axi_if.BRESP = cfg_bresp; end
                else b_cnt++;
            end
            if (axi_if.BVALID && axi_if.BREADY) begin
                b_fire = 1; b_pend = 0; b_cnt = 0; b_hs++;
                aw_got = 0; w_got = 0; wr_armed = 0;
            end
            if (r_fire) begin axi_if.RVALID = 1'b0; r_fire = 0; end
            if (r_pend && !axi_if.RVALID) begin
                if (r_cnt == r_dly) begin
                    axi_if.RVALID = 1'b1; axi_if.RRESP = cfg_rresp; axi_if.RDATA = cfg_rdata;
                end else r_cnt++;
            end
            if (axi_if.RVALID && axi_if.RREADY) begin
                r_fire = 1; r_pend = 0; r_cnt = 0; r_hs++; ar_got = 0;
            end
            if (axi_if.AWVALID && !aw_got) begin
                if (aw_wait && axi_if.AWADDR !== aw_prev) proto_err++;
                if (aw_cnt == aw_dly) begin
                    axi_if.AWREADY = 1'b1; aw_got = 1; aw_q.push_back(axi_if.AWADDR);
                    aw_wait = 0; aw_cnt = 0;
                end else begin
                    axi_if.AWREADY = 1'b0; aw_cnt++; aw_wait = 1; aw_prev = axi_if.AWADDR;
                end
            end else begin
                if (axi_if.AWVALID || aw_wait) proto_err++;
                axi_if.AWREADY = 1'b0; aw_wait = 0; aw_cnt = 0;
            end
            if (axi_if.WVALID && !w_got) begin
                if (w_wait && {axi_if.WDATA, axi_if.WSTRB} !== w_prev) proto_err++;
                if (w_cnt == w_dly) begin
                    axi_if.WREADY = 1'b1; w_got = 1;
                    wd_q.push_back(axi_if.WDATA); ws_q.push_back(axi_if.WSTRB);
                    w_wait = 0; w_cnt = 0;
                end else begin
                    axi_if.WREADY = 1'b0; w_cnt++; w_wait = 1; w_prev = {axi_if.WDATA, axi_if.WSTRB};
                end
            end else begin
                if (axi_if.WVALID || w_wait) proto_err++;
                axi_if.WREADY = 1'b0; w_wait = 0; w_cnt = 0;
            end
            if (aw_got && w_got && !wr_armed) begin wr_armed = 1; b_pend = 1; b_cnt = 0; end
            if (axi_if.ARVALID && !ar_got) begin
                if (ar_wait && axi_if.ARADDR !== ar_prev) proto_err++;
                if (ar_cnt == ar_dly) begin
                    axi_if.ARREADY = 1'b1; ar_got = 1; ar_q.push_back(axi_if.ARADDR);
                    ar_wait = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
                end else begin
                    axi_if.ARREADY = 1'b0; ar_cnt++; ar_wait = 1; ar_prev = axi_if.ARADDR;
                end
            end else begin
                if (axi_if.ARVALID || ar_wait) proto_err++;
                axi_if.ARREADY = 1'b0; ar_wait = 0; ar_cnt = 0;
            end
        end
    end

    task automatic clear_log();
        aw_q.delete(); wd_q.delete(); ws_q.delete(); ar_q.delete();
        b_hs = 0; r_hs = 0;
    endtask

    // Caller sits at a negedge; returns at the negedge of cycle 1 (cycle 0 = command handshake).
    task automatic issue_cmd(input logic wr, input addr_t a, input data_t d, input strb_t s);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < MAXW) begin @(negedge ACLK); n++; end
        if (n >= MAXW) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < MAXW) begin @(negedge ACLK); lat++; end
        if (lat >= MAXW) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({axi_if.AWVALID, axi_if.WVALID, axi_if.ARVALID, axi_if.BREADY, axi_if.RREADY,
             rsp_valid, cmd_ready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_handshake: got %b required 0000000", {axi_if.AWVALID,
                axi_if.WVALID, axi_if.ARVALID, axi_if.BREADY, axi_if.RREADY, rsp_valid, cmd_ready});
        end
        checks++;
        if ({axi_if.AWADDR, axi_if.WDATA, axi_if.WSTRB, axi_if.ARADDR, rsp_rdata, rsp_resp,
             rsp_write} !== '0) begin
            failures++;
            $display("FAIL reset_payload: awaddr=%h wdata=%h wstrb=%h araddr=%h rdata=%h resp=%b wr=%b required all 0",
                axi_if.AWADDR, axi_if.WDATA, axi_if.WSTRB, axi_if.ARADDR, rsp_rdata, rsp_resp, rsp_write);
        end
        checks++;
        if ({axi_if.AWCACHE, axi_if.ARCACHE, axi_if.AWPROT, axi_if.ARPROT} !== {4'b0011, 4'b0011, 3'b000, 3'b000}) begin
            failures++;
            $display("FAIL reset_attr: awcache=%b arcache=%b awprot=%b arprot=%b required 0011 0011 000 000",
                axi_if.AWCACHE, axi_if.ARCACHE, axi_if.AWPROT, axi_if.ARPROT);
        end
        cmd_valid = 1'b0;
        ARESETN = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    // Timeline: VALIDs from cycle 1 until their handshake, BREADY from the cycle after both, rsp after B.
    task automatic write_split(input int aw_d, input int w_d, input int b_d, input addr_t a,
                               input data_t d, input strb_t s, input resp_t br);
        int mx;
        int last;
        logic [3:0] exp;
        mx = (aw_d > w_d) ? aw_d : w_d;
        last = 3 + mx + b_d;
        clear_log();
        aw_dly = aw_d; w_dly = w_d; b_dly = b_d; cfg_bresp = br;
        issue_cmd(1'b1, a, d, s);
        for (int c = 1; c < last; c++) begin
            exp = {c <= 1 + aw_d, c <= 1 + w_d, (c >= 2 + mx) && (c <= 2 + mx + b_d), 1'b0};
            checks++;
            if ({axi_if.AWVALID, axi_if.WVALID, axi_if.BREADY, rsp_valid} !== exp ||
                (axi_if.AWVALID && axi_if.AWADDR !== a) ||
                (axi_if.WVALID && {axi_if.WDATA, axi_if.WSTRB} !== {d, s})) begin
                failures++;
                $display("FAIL write_timeline c%0d: awv/wv/bready/rspv=%b awaddr=%h wdata=%h wstrb=%h required %b %h %h %h",
                    c, {axi_if.AWVALID, axi_if.WVALID, axi_if.BREADY, rsp_valid}, axi_if.AWADDR,
                    axi_if.WDATA, axi_if.WSTRB, exp, a, d, s);
            end
            @(negedge ACLK);
        end
        checks++;
        if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.BREADY} !== {1'b1, 1'b1, 32'h0, br, 1'b0}) begin
            failures++;
            $display("FAIL write_rsp: valid=%b write=%b rdata=%h resp=%b bready=%b required 1 1 0 %b 0",
                rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.BREADY, br);
        end
        ack_rsp();
        checks++;
        if (aw_q.size() != 1 || wd_q.size() != 1 || b_hs != 1 || aw_q[0] !== a ||
            wd_q[0] !== d || ws_q[0] !== s) begin
            failures++;
            $display("FAIL write_handshakes: aw=%0d w=%0d b=%0d required 1 1 1 with addr %h data %h strb %h",
                aw_q.size(), wd_q.size(), b_hs, a, d, s);
        end
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL write_return_idle: cmd_ready/rsp_valid=%b required 10", {cmd_ready, rsp_valid});
        end
    endtask

    task automatic read_split(input int ar_d, input int r_d, input addr_t a, input data_t rd,
                              input resp_t rr);
        int last;
        logic [2:0] exp;
        last = 3 + ar_d + r_d;
        clear_log();
        ar_dly = ar_d; r_dly = r_d; cfg_rresp = rr; cfg_rdata = rd;
        issue_cmd(1'b0, a, 32'hFFFF_FFFF, 4'hF);
        for (int c = 1; c < last; c++) begin
            exp = {c <= 1 + ar_d, (c >= 2 + ar_d) && (c <= 2 + ar_d + r_d), 1'b0};
            checks++;
            if ({axi_if.ARVALID, axi_if.RREADY, rsp_valid} !== exp ||
                (axi_if.ARVALID && axi_if.ARADDR !== a) || axi_if.AWVALID || axi_if.WVALID) begin
                failures++;
                $display("FAIL read_timeline c%0d: arv/rready/rspv=%b araddr=%h awv=%b wv=%b required %b %h 0 0",
                    c, {axi_if.ARVALID, axi_if.RREADY, rsp_valid}, axi_if.ARADDR,
                    axi_if.AWVALID, axi_if.WVALID, exp, a);
            end
            @(negedge ACLK);
        end
        checks++;
        if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.RREADY} !== {1'b1, 1'b0, rd, rr, 1'b0}) begin
            failures++;
            $display("FAIL read_rsp: valid=%b write=%b rdata=%h resp=%b rready=%b required 1 0 %h %b 0",
                rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.RREADY, rd, rr);
        end
        ack_rsp();
        checks++;
        if (ar_q.size() != 1 || r_hs != 1 || ar_q[0] !== a || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_handshakes: ar=%0d r=%0d cmd_ready=%b required 1 1 1 with addr %h",
                ar_q.size(), r_hs, cmd_ready, a);
        end
    endtask

    task automatic test_write_basic();
        write_split(0, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
    endtask

    task automatic test_write_w_first();
        write_split(3, 0, 0, addr_t'($urandom), data_t'($urandom), 4'($urandom), RESP_OKAY);
    endtask

    task automatic test_write_aw_first();
        write_split(0, 2, 1, addr_t'($urandom), data_t'($urandom), 4'($urandom), RESP_DECERR);
    endtask

    task automatic test_read_delayed();
        read_split(2, 4, 32'h0000_0004, 32'h1234_5678, RESP_OKAY);
    endtask

    task automatic test_read_slverr();
        read_split(0, 1, addr_t'($urandom), data_t'($urandom), RESP_SLVERR);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checks++;
            if (axi_if.ARVALID !== 1'b0 || ar_q.size() != 1) begin
                failures++;
                $display("FAIL slverr_no_retry: arvalid=%b ar_count=%0d required 0 1", axi_if.ARVALID, ar_q.size());
            end
        end
    endtask

    task automatic test_rsp_stall();
        addr_t ra;
        data_t rd;
        int lat;
        ra = addr_t'($urandom);
        rd = data_t'($urandom);
        clear_log();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        cfg_bresp = RESP_EXOKAY; cfg_rresp = RESP_OKAY; cfg_rdata = rd;
        issue_cmd(1'b1, addr_t'($urandom), data_t'($urandom), 4'hA);
        wait_rsp(lat);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ra;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.ARVALID} !==
                {1'b0, 1'b1, 1'b1, 32'h0, RESP_EXOKAY, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold i%0d: cmd_ready=%b rspv=%b wr=%b rdata=%h resp=%b arv=%b required 0 1 1 0 01 0",
                    i, cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, axi_if.ARVALID);
            end
            @(negedge ACLK);
        end
        ack_rsp();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall_release: cmd_ready/rsp_valid=%b required 10", {cmd_ready, rsp_valid});
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, axi_if.ARVALID} !== 2'b01 || axi_if.ARADDR !== ra) begin
            failures++;
            $display("FAIL back_to_back_accept: cmd_ready/arv=%b araddr=%h required 01 %h",
                {cmd_ready, axi_if.ARVALID}, axi_if.ARADDR, ra);
        end
        wait_rsp(lat);
        checks++;
        if (lat != 3 || rsp_rdata !== rd || rsp_write !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_rsp: lat=%0d rdata=%h wr=%b required 3 %h 0", lat, rsp_rdata, rsp_write, rd);
        end
        ack_rsp();
    endtask

    task automatic test_reset_midflight();
        clear_log();
        aw_dly = 5; w_dly = 5; b_dly = 0;
        issue_cmd(1'b1, addr_t'($urandom), data_t'($urandom), 4'hF);
        @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({axi_if.AWVALID, axi_if.WVALID, axi_if.ARVALID, axi_if.BREADY, axi_if.RREADY,
             rsp_valid, cmd_ready} !== 7'b0 || axi_if.AWADDR !== '0) begin
            failures++;
            $display("FAIL midflight_reset: valids/readies=%b awaddr=%h required 0000000 0",
                {axi_if.AWVALID, axi_if.WVALID, axi_if.ARVALID, axi_if.BREADY, axi_if.RREADY,
                 rsp_valid, cmd_ready}, axi_if.AWADDR);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL midflight_release_early: cmd_ready=%b required 0", cmd_ready);
        end
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midflight_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
        write_split(0, 0, 0, addr_t'($urandom), data_t'($urandom), 4'($urandom), RESP_OKAY);
    endtask

    task automatic test_random();
        logic  wr;
        addr_t a;
        data_t d, rd;
        strb_t s;
        resp_t rr;
        int    d0, d1, d2, mx, exp_lat, lat;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom);
            a = addr_t'($urandom); d = data_t'($urandom); rd = data_t'($urandom);
            s = 4'($urandom); rr = 2'($urandom);
            d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
            clear_log();
            aw_dly = d0; w_dly = d1; b_dly = d2; ar_dly = d0; r_dly = d2;
            cfg_bresp = rr; cfg_rresp = rr; cfg_rdata = rd;
            mx = (d0 > d1) ? d0 : d1;
            exp_lat = wr ? (3 + mx + d2) : (3 + d0 + d2);
            issue_cmd(wr, a, d, s);
            wait_rsp(lat);
            checks++;
            if (lat != exp_lat || rsp_write !== wr || rsp_resp !== rr ||
                rsp_rdata !== (wr ? 32'h0 : rd)) begin
                failures++;
                $display("FAIL random_rsp i%0d: lat=%0d wr=%b resp=%b rdata=%h required %0d %b %b %h",
                    i, lat, rsp_write, rsp_resp, rsp_rdata, exp_lat, wr, rr, wr ? 32'h0 : rd);
            end
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
            ack_rsp();
            checks++;
            if (wr ? (aw_q.size() != 1 || wd_q.size() != 1 || ar_q.size() != 0 || aw_q[0] !== a ||
                      wd_q[0] !== d || ws_q[0] !== s)
                   : (ar_q.size() != 1 || aw_q.size() != 0 || wd_q.size() != 0 || ar_q[0] !== a)) begin
                failures++;
                $display("FAIL random_bus i%0d: aw=%0d w=%0d ar=%0d wr=%b required exactly one handshake per used channel at addr %h",
                    i, aw_q.size(), wd_q.size(), ar_q.size(), wr, a);
            end
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL random_ready i%0d: cmd_ready=%b required 1", i, cmd_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_w_first();
        test_write_aw_first();
        test_read_delayed();
        test_read_slverr();
        test_rsp_stall();
        test_reset_midflight();
        test_random();
        checks++;
        if (proto_err != 0) begin
            failures++;
            $display("FAIL protocol: violations=%0d required 0", proto_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
